// File: rtl/ysyx_23060171_pcu.sv
// Program-counter unit: owns the architectural PC, offers fetch addresses to the IFU
// and selects the next PC when the outstanding instruction resolves.
module ysyx_23060171_pcu #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_VEC   = XLEN'(32'h8000_0000),
  parameter bit               ALIGN_CHECK = 1'b1,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  input  logic             res_valid,
  input  logic [6:0]       res_opcode,
  input  logic [2:0]       res_f3,
  input  logic [11:0]      res_f12,
  input  logic             res_zf,
  input  logic             res_cmp,
  input  logic [XLEN-1:0]  res_dnpc,
  input  logic [XLEN-1:0]  res_dnpc_r,
  input  logic [XLEN-1:0]  csr_mtvec,
  input  logic [XLEN-1:0]  csr_mepc,
  input  logic             trap_valid,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;
  localparam logic [6:0]  OP_JALR    = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;

  typedef enum logic [1:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    SEL_SNPC,
    SEL_DNPC,
    SEL_DNPC_R,
    SEL_MEPC,
    SEL_ECALL,
    SEL_TRAP,
    SEL_HALT
  } sel_t;

  state_t            state, state_n;
  sel_t              sel;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   snpc;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_next;
  logic              trap_pend;
  logic              trap_now;
  logic              br_taken;
  logic              resolve;
  logic              check_target;
  logic              misaligned;

  assign snpc     = pc + XLEN'(4);
  assign trap_now = trap_pend | trap_valid;
  assign resolve  = (state == S_WAIT) && res_valid;

  assign out_valid = (state == S_ISSUE);
  assign out_pc    = pc;
  assign halted    = (state == S_HALT);

  // Redirect source decode; a pending or same-cycle trap overrides everything.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sel      = SEL_SNPC;
    br_taken = 1'b0;
    case (res_f3)
      3'b000:         br_taken = res_zf;
      3'b001:         br_taken = !res_zf;
      3'b100, 3'b110: br_taken = res_cmp;
      3'b101, 3'b111: br_taken = !res_cmp;
      default:        br_taken = 1'b0;
    endcase
    if (trap_now) begin
      sel = SEL_TRAP;
    end else begin
      case (res_opcode)
        OP_SYSTEM: begin
          if (res_f3 == 3'b000) begin
            case (res_f12)
              F12_MRET:   sel = SEL_MEPC;
              F12_ECALL:  sel = SEL_ECALL;
              F12_EBREAK: sel = SEL_HALT;
              default:    sel = SEL_SNPC;
            endcase
          end
        end
        OP_JAL:    sel = SEL_DNPC;
        OP_JALR:   sel = SEL_DNPC_R;
        OP_BRANCH: sel = br_taken ? SEL_DNPC : SEL_SNPC;
        default:   sel = SEL_SNPC;
      endcase
    end
  end

  always_comb begin
    target = snpc;
    case (sel)
      SEL_DNPC:            target = res_dnpc;
      SEL_DNPC_R:          target = res_dnpc_r & ~XLEN'(1);
      SEL_MEPC:            target = csr_mepc;
      SEL_ECALL, SEL_TRAP: target = csr_mtvec;
      SEL_HALT:            target = pc;
      default:             target = snpc;
    endcase
  end

  // Only computed control-flow targets are alignment-checked; CSR vectors are trusted.
  assign check_target = (sel == SEL_DNPC) || (sel == SEL_DNPC_R);
  assign misaligned   = ALIGN_CHECK && check_target && (target[1:0] != 2'b00);
  assign pc_next      = misaligned ? csr_mtvec : target;

  always_comb begin
    state_n = state;
    case (state)
      S_BOOT:  state_n = S_ISSUE;
      S_ISSUE: if (out_ready) state_n = S_WAIT;
      S_WAIT:  if (res_valid) state_n = (sel == SEL_HALT) ? S_HALT : S_ISSUE;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VEC;
      trap_pend     <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      redirect_cnt  <= '0;
    end else begin
      misalign <= 1'b0;
      if (resolve) begin
        pc        <= pc_next;
        trap_pend <= 1'b0;
        if (misaligned) begin
          misalign      <= 1'b1;
          misalign_addr <= target;
        end
        if (sel != SEL_SNPC) begin
          redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
      end else if (trap_valid && (state != S_HALT)) begin
        trap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060171_pcu.sv
// Self-checking bench for ysyx_23060171_pcu: directed vector table, hand-written
// corner sequences and randomized instructions against a behavioural model.
module tb_ysyx_23060171_pcu;

  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [31:0] RVEC      = 32'h8000_0000;
  localparam logic [31:0] MTVEC     = 32'h8000_1000;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic        zf;
    logic        cmp;
    logic [31:0] dnpc;
    logic [31:0] dnpc_r;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] exp_pc;
    bit          redir;
    bit          mis;
    logic [31:0] mis_addr;
  } vec_t;

  logic        clk, rst_n;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic        res_valid;
  logic [6:0]  res_opcode;
  logic [2:0]  res_f3;
  logic [11:0] res_f12;
  logic        res_zf, res_cmp;
  logic [31:0] res_dnpc, res_dnpc_r, csr_mtvec, csr_mepc;
  logic        trap_valid;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        halted;
  logic [31:0] redirect_cnt;

  ysyx_23060171_pcu dut (
    .clk(clk), .rst_n(rst_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .res_valid(res_valid), .res_opcode(res_opcode), .res_f3(res_f3), .res_f12(res_f12),
    .res_zf(res_zf), .res_cmp(res_cmp), .res_dnpc(res_dnpc), .res_dnpc_r(res_dnpc_r),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .trap_valid(trap_valid),
    .misalign(misalign), .misalign_addr(misalign_addr), .halted(halted),
    .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] m_pc, m_cnt, m_mis_addr;
  bit          m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] f12,
                                input logic zf, input logic cmp,
                                input logic [31:0] dn, input logic [31:0] dr);
    instr_t r;
    r.op = op; r.f3 = f3; r.f12 = f12; r.zf = zf; r.cmp = cmp; r.dnpc = dn; r.dnpc_r = dr;
    return r;
  endfunction

  // Reference: next PC from the architectural rules, written as a plain decision list.
  task automatic ref_step(input logic [31:0] pc, input instr_t in, input bit trap,
                          input logic [31:0] mtvec, input logic [31:0] mepc,
                          output logic [31:0] npc, output bit halt, output bit mis,
                          output logic [31:0] mis_addr, output bit redir);
    logic [31:0] seq_pc, tgt;
    bit          computed, taken;
    seq_pc   = pc + 32'd4;
    tgt      = seq_pc;
    computed = 0;
    halt     = 0;
    redir    = 1;
    taken    = 0;
    if (trap) tgt = mtvec;
    else if (in.op == OP_SYSTEM && in.f3 == 3'd0 && in.f12 == 12'h302) tgt = mepc;
    else if (in.op == OP_SYSTEM && in.f3 == 3'd0 && in.f12 == 12'h000) tgt = mtvec;
    else if (in.op == OP_SYSTEM && in.f3 == 3'd0 && in.f12 == 12'h001) begin halt = 1; tgt = pc; end
    else if (in.op == OP_JAL)  begin tgt = in.dnpc; computed = 1; end
    else if (in.op == OP_JALR) begin tgt = in.dnpc_r - {31'd0, in.dnpc_r[0]}; computed = 1; end
    else if (in.op == OP_BRANCH) begin
      if (in.f3 == 3'd0) taken = in.zf;
      if (in.f3 == 3'd1) taken = !in.zf;
      if (in.f3 == 3'd4 || in.f3 == 3'd6) taken = in.cmp;
      if (in.f3 == 3'd5 || in.f3 == 3'd7) taken = !in.cmp;
      if (taken) begin tgt = in.dnpc; computed = 1; end
      else redir = 0;
    end else redir = 0;
    mis      = computed && (tgt % 4 != 0);
    mis_addr = tgt;
    npc      = mis ? mtvec : tgt;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("issue_timeout", out_valid, 1);
  endtask

  // Called at a negedge; returns at the negedge after the resolution edge.
  task automatic run_instr(input instr_t in, input int stall, input bit tv_issue,
                           input bit tv_res, output bit trap);
    wait_issue();
    check("issue_pc", out_pc, m_pc);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_pc", out_pc, m_pc);
    end
    out_ready  = 1'b1;
    trap_valid = tv_issue;
    if (tv_issue) m_pend = 1;
    @(negedge clk);
    trap_valid = 1'b0;
    check("wait_valid", out_valid, 0);
    check("mis_clear", misalign, 0);
    res_opcode = in.op;  res_f3 = in.f3;  res_f12 = in.f12;
    res_zf = in.zf;  res_cmp = in.cmp;  res_dnpc = in.dnpc;  res_dnpc_r = in.dnpc_r;
    res_valid  = 1'b1;
    trap_valid = tv_res;
    trap       = m_pend | tv_res;
    m_pend     = 0;
    @(negedge clk);
    res_valid  = 1'b0;
    trap_valid = 1'b0;
  endtask

  task automatic post_check(input string name, input bit exp_mis);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_pc"}, out_pc, m_pc);
    check({name, "_mis"}, misalign, exp_mis);
    check({name, "_misaddr"}, misalign_addr, m_mis_addr);
    check({name, "_cnt"}, redirect_cnt, m_cnt);
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    logic [6:0]  ops [6];
    logic [11:0] f12s [3];
    ops[0] = OP_IMM; ops[1] = OP_REG; ops[2] = OP_SYSTEM;
    ops[3] = OP_JAL; ops[4] = OP_JALR; ops[5] = OP_BRANCH;
    f12s[0] = 12'h302; f12s[1] = 12'h000; f12s[2] = 12'h0ab;
    r.op     = ops[$urandom_range(0, 5)];
    r.f3     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
    r.f12    = f12s[$urandom_range(0, 2)];
    r.zf     = 1'($urandom);
    r.cmp    = 1'($urandom);
    r.dnpc   = ($urandom & 32'hffff_fffc) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    r.dnpc_r = $urandom;
    return r;
  endfunction

  vec_t        tbl [14];
  instr_t      ins;
  bit          trap, halt, mis, redir;
  logic [31:0] npc, maddr;

  initial begin
    tbl[0]  = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0100, 0), 32'h8000_0100, 1, 0, 0};
    tbl[1]  = '{mk(OP_BRANCH, 3'd0, 12'h0,   1, 0, 32'h8000_0040, 0), 32'h8000_0040, 1, 0, 0};
    tbl[2]  = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0100, 0), 32'h8000_0100, 1, 0, 0};
    tbl[3]  = '{mk(OP_BRANCH, 3'd1, 12'h0,   1, 0, 32'h8000_0040, 0), 32'h8000_0104, 0, 0, 0};
    tbl[4]  = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0100, 0), 32'h8000_0100, 1, 0, 0};
    tbl[5]  = '{mk(OP_BRANCH, 3'd6, 12'h0,   0, 1, 32'h8000_0040, 0), 32'h8000_0040, 1, 0, 0};
    tbl[6]  = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0100, 0), 32'h8000_0100, 1, 0, 0};
    tbl[7]  = '{mk(OP_BRANCH, 3'd5, 12'h0,   0, 1, 32'h8000_0040, 0), 32'h8000_0104, 0, 0, 0};
    tbl[8]  = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0200, 0), 32'h8000_0200, 1, 0, 0};
    tbl[9]  = '{mk(OP_JALR,   3'd0, 12'h0,   0, 0, 0, 32'h8000_0203), MTVEC, 1, 1, 32'h8000_0202};
    tbl[10] = '{mk(OP_SYSTEM, 3'd0, 12'h123, 0, 0, 0, 0), 32'h8000_1004, 0, 0, 0};
    tbl[11] = '{mk(OP_SYSTEM, 3'd0, 12'h000, 0, 0, 0, 0), MTVEC, 1, 0, 0};
    tbl[12] = '{mk(OP_BRANCH, 3'd2, 12'h0,   1, 1, 32'h8000_0040, 0), 32'h8000_1004, 0, 0, 0};
    tbl[13] = '{mk(OP_JAL,    3'd0, 12'h0,   0, 0, 32'h8000_0006, 0), MTVEC, 1, 1, 32'h8000_0006};

    rst_n = 1'b0; out_ready = 1'b1; res_valid = 1'b0; trap_valid = 1'b0;
    res_opcode = '0; res_f3 = '0; res_f12 = '0; res_zf = 1'b0; res_cmp = 1'b0;
    res_dnpc = '0; res_dnpc_r = '0; csr_mtvec = MTVEC; csr_mepc = 32'h8000_0300;
    m_pc = RVEC; m_cnt = 0; m_mis_addr = 0; m_pend = 0;

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, RVEC);
    check("rst_halted", halted, 0);
    check("rst_cnt", redirect_cnt, 0);
    check("rst_misaddr", misalign_addr, 0);
    rst_n = 1'b1;
    #1 check("boot_valid", out_valid, 0);
    @(negedge clk);
    check("boot_1cycle", out_valid, 1);

    // addi then jal to 0x10
    run_instr(mk(OP_IMM, 0, 0, 0, 0, 32'h8000_0044, 0), 0, 0, 0, trap);
    m_pc = 32'h8000_0004;
    post_check("addi", 0);
    run_instr(mk(OP_JAL, 0, 0, 0, 0, 32'h8000_0010, 0), 0, 0, 0, trap);
    m_pc = 32'h8000_0010; m_cnt++;
    post_check("jal10", 0);

    // Back-pressure: address held five cycles; a stray res_valid in ISSUE is ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_opcode = OP_JAL; res_dnpc = 32'h8000_0ff0;
      res_valid  = (i == 1);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_pc", out_pc, 32'h8000_0010);
    end
    res_valid = 1'b0;
    check("hold_cnt", redirect_cnt, m_cnt);

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].in, 0, 0, 0, trap);
      m_pc = tbl[i].exp_pc;
      if (tbl[i].redir) m_cnt++;
      if (tbl[i].mis) m_mis_addr = tbl[i].mis_addr;
      post_check($sformatf("vec%0d", i), tbl[i].mis);
    end

    // Trap during the accepted fetch beats the following mret, then mret returns to mepc.
    run_instr(mk(OP_SYSTEM, 0, 12'h302, 0, 0, 0, 0), 1, 1, 0, trap);
    m_pc = MTVEC; m_cnt++;
    post_check("trap_mret", 0);
    run_instr(mk(OP_SYSTEM, 0, 12'h302, 0, 0, 0, 0), 0, 0, 0, trap);
    m_pc = 32'h8000_0300; m_cnt++;
    post_check("mret", 0);
    // Same-cycle trap and resolution: trap wins, one count.
    run_instr(mk(OP_JAL, 0, 0, 0, 0, 32'h8000_0400, 0), 0, 0, 1, trap);
    m_pc = MTVEC; m_cnt++;
    post_check("trap_same", 0);

    for (int n = 0; n < 300; n++) begin
      ins = rand_instr();
      csr_mepc = $urandom & 32'hffff_fffc;
      run_instr(ins, $urandom_range(0, 2), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0), trap);
      ref_step(m_pc, ins, trap, csr_mtvec, csr_mepc, npc, halt, mis, maddr, redir);
      m_pc = npc;
      if (redir) m_cnt++;
      if (mis) m_mis_addr = maddr;
      post_check("rand", mis);
    end

    // ebreak halts for good; a resolution in HALT changes nothing.
    run_instr(mk(OP_SYSTEM, 0, 12'h001, 0, 0, 0, 0), 0, 0, 0, trap);
    m_cnt++;
    for (int i = 0; i < 4; i++) begin
      res_valid = (i == 1);
      res_opcode = OP_JAL;
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_valid", out_valid, 0);
      check("halt_pc", out_pc, m_pc);
      check("halt_cnt", redirect_cnt, m_cnt);
    end
    res_valid = 1'b0;

    // Asynchronous reset mid-cycle, away from any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("arst_halted", halted, 0);
    check("arst_valid", out_valid, 0);
    check("arst_pc", out_pc, RVEC);
    check("arst_cnt", redirect_cnt, 0);
    check("arst_misaddr", misalign_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, RVEC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060171_pcu.md
Name: ysyx_23060171_pcu

Overview:
Parametrised program-counter unit. Owns the architectural PC register, issues fetch addresses to the IFU over a valid/ready handshake, and computes the next PC when the decode/execute stage reports the resolution of the issued instruction. Redirect sources are branch, jal, jalr, mret, ecall, external trap, and misaligned target. Adds ebreak halt, a pending-trap latch and a redirect performance counter.

Parameters:
XLEN, 32, PC/address width (32 or 64)
RESET_VEC, 32'h8000_0000 zero-extended to XLEN, PC value after reset
ALIGN_CHECK, 1, 1 = targets with pc[1:0]!=0 trap to mtvec; 0 = no check
CNT_W, 32, width of redirect counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
out_valid  out  1  fetch address valid
out_ready  in  1  IFU accepts address
out_pc  out  XLEN  fetch address
res_valid  in  1  resolution of the outstanding instruction (1-cycle pulse)
res_opcode  in  7  instruction opcode
res_f3  in  3  funct3
res_f12  in  12  funct12 (SYSTEM)
res_zf  in  1  ALU zero flag (rs1==rs2)
res_cmp  in  1  ALU less-than result (signed/unsigned per f3)
res_dnpc  in  XLEN  pc+imm target
res_dnpc_r  in  XLEN  rs1+imm target (jalr)
csr_mtvec  in  XLEN  trap vector
csr_mepc  in  XLEN  return address
trap_valid  in  1  external/interrupt trap request (level, sampled each cycle)
misalign  out  1  1-cycle pulse: misaligned target detected
misalign_addr  out  XLEN  offending target, held until next pulse
halted  out  1  ebreak retired, unit stopped
redirect_cnt  out  CNT_W  count of non-sequential next-PC selections

Behaviour:
- Clock and reset: one clock, clk; reset rst_n asynchronous, active-low. Reset values: pc=RESET_VEC, state=BOOT, out_valid=0, misalign=0, misalign_addr=0, halted=0, redirect_cnt=0, trap_pend=0.
- States: BOOT, ISSUE, WAIT, HALT.
  - BOOT: one cycle after reset release, then ISSUE.
  - ISSUE: out_valid=1, out_pc=pc. out_pc is stable while out_valid && !out_ready. On out_valid && out_ready, go to WAIT. out_valid is never retracted before acceptance.
  - WAIT: out_valid=0. res_valid in cycle N loads the new pc and enters ISSUE in cycle N+1, so redirect latency is 1 cycle. res_valid in ISSUE/BOOT/HALT is ignored.
  - HALT: out_valid=0 and halted=1 until reset.
- Trap sampling:
  - trap_valid high in any non-HALT cycle sets trap_pend.
  - trap_pend, or trap_valid in the same cycle, takes priority at the next resolution: next pc = csr_mtvec, then trap_pend is cleared.
  - A trap in ISSUE does not cancel the offered or accepted fetch.
- Next-PC selection at resolution, highest priority first:
  - trap: csr_mtvec.
  - SYSTEM (1110011), f3=000:
    - f12=0x302 (mret): csr_mepc.
    - f12=0x000 (ecall): csr_mtvec.
    - f12=0x001 (ebreak): enter HALT, pc unchanged.
    - other: snpc.
  - jal (1101111): res_dnpc.
  - jalr (1100111): res_dnpc_r with bit0 forced to 0.
  - BRANCH (1100011):
    - beq: taken iff zf.
    - bne: taken iff !zf.
    - blt/bltu: taken iff cmp.
    - bge/bgeu: taken iff !cmp.
    - f3 010/011: not taken.
    - taken selects res_dnpc, otherwise snpc.
  - anything else: snpc.
- snpc = pc + 4, truncated to XLEN, so it wraps modulo 2^XLEN.
- Misaligned target: if ALIGN_CHECK=1 and the selected non-trap target has bits[1:0]!=0:
  - pc = csr_mtvec.
  - misalign pulses 1 cycle.
  - misalign_addr = target.
  - Trap/mtvec/mepc targets are never checked.
- redirect_cnt increments by 1 on every resolution whose selection is not snpc, including trap, misalign and ebreak. It wraps at 2^CNT_W.
- Simultaneous res_valid and trap_valid in WAIT: trap wins; redirect_cnt increments once.
- Asynchronous reset assertion mid-operation returns all state to reset values immediately, independent of clk.

Test Plan:
- Reset release with out_ready=1 -> BOOT for 1 cycle, then out_pc=0x8000_0000 valid. Resolve addi (0010011) -> next out_pc=0x8000_0004 one cycle after res_valid; redirect_cnt=0.
- Hold out_ready=0 for 5 cycles at pc 0x8000_0010 -> out_valid=1 and out_pc stable for all 5 cycles; no state change.
- Branches at pc 0x8000_0100, dnpc 0x8000_0040:
  - beq zf=1 -> 0x8000_0040.
  - bne zf=1 -> 0x8000_0104.
  - bltu cmp=1 -> 0x8000_0040.
  - bge cmp=1 -> 0x8000_0104.
  - redirect_cnt ends at 2.
- jalr with dnpc_r=0x8000_0203, ALIGN_CHECK=1 -> bit0 cleared gives 0x8000_0202, which is still misaligned. Response: misalign pulse, misalign_addr=0x8000_0202, next out_pc=mtvec=0x8000_1000.
- trap_valid pulse in ISSUE while the fetch is accepted, then mret resolution -> next pc=mtvec (trap wins over mepc); trap_pend cleared. A following mret with mepc=0x8000_0300 -> 0x8000_0300.
- ebreak resolution -> halted=1 and out_valid=0 forever. Assert rst_n=0 mid-clock -> outputs reset asynchronously; fetch restarts at RESET_VEC after release.
